// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and fetch-buffer entry type
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] ins;
    logic            filled;
  } ifb_entry_t;

endpackage

// File: rtl/ifetch_buf_if.sv
// rtl/ifetch_buf_if.sv - fetch-stage, instruction-memory and decode signals of ifetch_buf
interface ifetch_buf_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] addr;
  logic            mispred;
  logic            ready;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            ins_valid;
  logic [ILEN-1:0] ins;
  logic [XLEN-1:0] ins_addr;
  logic            dec_ready;

  modport slave (
    input  addr, mispred, imem_rvalid, imem_rdata, dec_ready,
    output ready, imem_req, imem_addr, ins_valid, ins, ins_addr
  );

  modport master (
    output addr, mispred, imem_rvalid, imem_rdata, dec_ready,
    input  ready, imem_req, imem_addr, ins_valid, ins, ins_addr
  );

endinterface

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - in-order instruction fetch buffer with mispredict flush
// Optional same-cycle response-to-decode bypass: define IFB_BYPASS_EN.
module ifetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  ifetch_buf_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

  ifb_entry_t    r_q [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_fill_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_drop_cnt;
  logic          r_active;

  logic [PW-1:0] w_alloc_cnt;
  logic [PW-1:0] w_outst_cnt;
  logic [PW-1:0] w_inflight;
  logic [PW:0]   w_occupied;
  logic          w_ready;
  logic          w_req;
  logic          w_resp_drop;
  logic          w_resp_fill;
  logic          w_flush_rsp;
  logic          w_bypass;
  logic          w_ins_valid;
  logic          w_pop;
  ifb_entry_t    w_head;

  assign w_alloc_cnt = r_wr_ptr - r_rd_ptr;
  assign w_outst_cnt = r_wr_ptr - r_fill_ptr;
  assign w_inflight  = r_drop_cnt + w_outst_cnt;

  // Responses still owed for flushed requests hold credit until they drain.
  assign w_occupied  = {1'b0, w_alloc_cnt} + {1'b0, r_drop_cnt};
  assign w_ready     = r_active & (bus.mispred | (w_occupied < DEPTH_C));
  assign w_req       = w_ready & ~bus.mispred;

  assign w_resp_drop = bus.imem_rvalid & (r_drop_cnt != '0);
  assign w_resp_fill = bus.imem_rvalid & (r_drop_cnt == '0) & (w_outst_cnt != '0) & ~bus.mispred;
  assign w_flush_rsp = bus.imem_rvalid & (w_inflight != '0);

  assign w_head = r_q[r_rd_ptr[IW-1:0]];

`ifdef IFB_BYPASS_EN
  assign w_bypass = w_resp_fill & (r_fill_ptr == r_rd_ptr);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_ins_valid = w_head.filled | w_bypass;
  assign w_pop       = w_ins_valid & bus.dec_ready & ~bus.mispred;

  assign bus.ready     = w_ready;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = bus.addr;
  assign bus.ins_valid = w_ins_valid;
  assign bus.ins       = w_bypass ? bus.imem_rdata : w_head.ins;
  assign bus.ins_addr  = w_head.addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active   <= 1'b0;
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_active <= 1'b1;
      if (bus.mispred) begin
        // A response landing in the flush cycle is one of the flushed requests.
        r_drop_cnt <= w_inflight - (w_flush_rsp ? PTR_ONE : '0);
        r_wr_ptr   <= '0;
        r_fill_ptr <= '0;
        r_rd_ptr   <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_q[i].filled <= 1'b0;
        end
      end else begin
        if (w_resp_drop) begin
          r_drop_cnt <= r_drop_cnt - PTR_ONE;
        end
        if (w_req) begin
          r_q[r_wr_ptr[IW-1:0]].addr   <= bus.addr;
          r_q[r_wr_ptr[IW-1:0]].filled <= 1'b0;
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_resp_fill) begin
          r_q[r_fill_ptr[IW-1:0]].ins    <= bus.imem_rdata;
          r_q[r_fill_ptr[IW-1:0]].filled <= 1'b1;
          r_fill_ptr <= r_fill_ptr + PTR_ONE;
        end
        // Placed after the fill so a bypassed entry is never left marked filled.
        if (w_pop) begin
          r_q[r_rd_ptr[IW-1:0]].filled <= 1'b0;
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule
